hex_display_scan_ctrl: RTL and testbench
========================================

Name: hex_display_scan_ctrl

Overview:
Parametrised, time-multiplexed N-digit hexadecimal 7-segment display driver for common-anode, active-low-cathode display boards. It holds a full multi-digit value plus per-digit decimal points and enables, scans one digit at a time at a programmable refresh rate, and decodes each nibble to segment patterns. Host logic writes a new value with a load strobe. The update is double-buffered and committed only at a frame boundary, so the display never shows a torn value.

Parameters:
NUM_DIGITS, 4, number of digits and anodes (1..16)
REFRESH_DIV, 50000, clk cycles each digit stays selected (must exceed BLANK_CYCLES, >=2)
BLANK_CYCLES, 16, cycles at the start of each digit slot with all anodes off (anti-ghosting guard; 0 disables the guard)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
load  in  1  single-cycle strobe; captures value_in/dp_in/digit_en into the shadow register
value_in  in  4*NUM_DIGITS  hex value; nibble d drives digit d (digit 0 = least significant, bits [3:0])
dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high
digit_en  in  NUM_DIGITS  per-digit enable, active-high
seg_n  out  7  cathodes {CA,CB,CC,CD,CE,CF,CG}, active-low, CA is the MSB
dp_n  out  1  decimal-point cathode, active-low
an_n  out  NUM_DIGITS  anodes, active-low, an_n[d] selects digit d
frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0
pending  out  1  high while the shadow register holds an uncommitted update

Behaviour:
- Reset (rst_n low, asynchronous): an_n all 1, seg_n 7'b1111111, dp_n 1, frame_done 0, pending 0. The prescaler, digit index, shadow register and active register all clear to 0.
- Prescaler counts 0..REFRESH_DIV-1. tick = (prescaler == REFRESH_DIV-1). On tick, the prescaler returns to 0 and the index advances. The index wraps from NUM_DIGITS-1 to 0.
- Frame boundary = tick while index == NUM_DIGITS-1. On that same cycle, frame_done goes high for exactly 1 cycle.
- On a frame boundary with pending=1: active <= shadow and pending <= 0.
- load, not at a commit: shadow <= inputs and pending <= 1. If an update is already pending, the new load overwrites it (last write wins).
- load and commit in the same cycle: active takes the OLD shadow contents; shadow takes the new inputs; pending stays 1.
- Outputs are registered and lag the index/prescaler state by 1 cycle. Each cycle the output registers compute:
  - guard = (prescaler < BLANK_CYCLES)
  - an_n = ~(1<<index) if active digit_en[index]=1 and guard=0; otherwise all 1
  - seg_n = decode(active nibble[index]); dp_n = ~active dp[index]
  - seg_n and dp_n are driven even while the anodes are off.
- Decode table, seg_n = CA..CG:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, B=1100000
  - C=0110001, D=1000010, E=0110000, F=0111000
- Scan period = NUM_DIGITS*REFRESH_DIV cycles. Commit latency from load is at most one frame plus 1 cycle to the outputs.
- Reset mid-frame: the pending update is discarded. Scanning restarts at digit 0 with a blank (zeroed) active register, so all anodes stay off until the first commit of an enabled value.
- NUM_DIGITS=1: every tick is a frame boundary.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digit d>0 is suppressed (an_n all 1 for its slot) when the active nibbles d..NUM_DIGITS-1 are all zero and active dp[d]=0. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Undefined: all enabled digits display, including leading zeros. Port list is identical either way.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
1. Reset release with no load -> an_n=4'b1111, seg_n=7'b1111111 and dp_n=1 throughout; frame_done pulses every 16 cycles.
2. load value_in=16'h3A7F, digit_en=4'hF, dp_in=0 -> pending=1 until the next frame_done. In the following frame:
   - digit 0: an_n=1110, seg_n=0111000 (F)
   - digit 1: an_n=1101, seg_n=0001111 (7)
   - digit 2: an_n=1011, seg_n=0001000 (A)
   - digit 3: an_n=0111, seg_n=0000110 (3)
   - each digit is active for 3 cycles after 1 blank cycle.
3. load 16'h1111, then 16'h2222 before the frame boundary -> only 2222 ever displays (seg_n=0010010); 1111 never appears.
4. load asserted exactly on a frame-boundary cycle while 16'h1111 is pending -> the next frame shows 1111; pending stays 1; 16'h2222 shows one frame later.
5. digit_en=4'b0101, dp_in=4'b0001 -> an_n stays 1111 during the digit 1 and digit 3 slots; dp_n=0 only in the digit 0 slot.
6. rst_n pulsed low mid-slot with an update pending -> outputs return to reset values immediately (asynchronously); pending=0; the old value is not displayed after release. With LEADING_ZERO_BLANK_EN defined, value 16'h0005 -> only the digit 0 anode goes low.

Source files
------------

// File: rtl/hex_display_scan_ctrl_if.sv
// Host/display bundle for hex_display_scan_ctrl: value load side plus the
// multiplexed cathode/anode drive and status outputs.
interface hex_display_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic [6:0]                seg_n;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_done;
    logic                      pending;

    modport master (
        output load, value_in, dp_in, digit_en,
        input  seg_n, dp_n, an_n, frame_done, pending
    );

    modport slave (
        input  load, value_in, dp_in, digit_en,
        output seg_n, dp_n, an_n, frame_done, pending
    );
endinterface

// File: rtl/hex_display_scan_ctrl.sv
// Time-multiplexed N-digit hex 7-segment driver with frame-aligned double buffering.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module hex_display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_display_scan_ctrl_if.slave disp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_PENULT = PRE_W'(REFRESH_DIV - 2);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0001100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [PRE_W-1:0]               presc_r;
    logic [IDX_W-1:0]               idx_r;
    logic [NUM_DIGITS-1:0][3:0]     shd_val_r;
    logic [NUM_DIGITS-1:0][3:0]     act_val_r;
    logic [NUM_DIGITS-1:0]          shd_dp_r;
    logic [NUM_DIGITS-1:0]          shd_en_r;
    logic [NUM_DIGITS-1:0]          act_dp_r;
    logic [NUM_DIGITS-1:0]          act_en_r;
    logic                           pending_r;
    logic [6:0]                     seg_n_r;
    logic                           dp_n_r;
    logic [NUM_DIGITS-1:0]          an_n_r;
    logic                           frame_done_r;

    logic                           tick_s;
    logic                           boundary_s;
    logic                           pre_boundary_s;
    logic                           guard_s;
    logic                           suppress_s;
    logic [NUM_DIGITS-1:0]          an_n_s;

    assign tick_s         = (presc_r == PRE_LAST);
    assign boundary_s     = tick_s && (idx_r == LAST_IDX);
    // frame_done is registered one cycle early so it coincides with the boundary cycle
    assign pre_boundary_s = (presc_r == PRE_PENULT) && (idx_r == LAST_IDX);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign guard_s = 1'b0;
        end else begin : g_guard
            assign guard_s = (presc_r < PRE_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS:0] upper_zero_s;

    // Digit d is a leading zero when it and every more significant nibble are zero
    always_comb begin
        upper_zero_s             = '0;
        upper_zero_s[NUM_DIGITS] = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            upper_zero_s[d] = upper_zero_s[d+1] && (act_val_r[d] == 4'h0);
        end
        suppress_s = (idx_r != '0) && upper_zero_s[idx_r] && !act_dp_r[idx_r];
    end
`else
    assign suppress_s = 1'b0;
`endif

    // Anode select for the current slot
    always_comb begin
        an_n_s = '1;
        if (act_en_r[idx_r] && !guard_s && !suppress_s) begin
            an_n_s[idx_r] = 1'b0;
        end else begin
            an_n_s = '1;
        end
    end

    // Prescaler, digit index, shadow/active buffers and frame strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r      <= '0;
            idx_r        <= '0;
            shd_val_r    <= '0;
            shd_dp_r     <= '0;
            shd_en_r     <= '0;
            act_val_r    <= '0;
            act_dp_r     <= '0;
            act_en_r     <= '0;
            pending_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (tick_s) begin
                presc_r <= '0;
                idx_r   <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
            end else begin
                presc_r <= presc_r + PRE_W'(1);
            end

            // A load on the commit cycle still hands the old shadow to active
            if (boundary_s && pending_r) begin
                act_val_r <= shd_val_r;
                act_dp_r  <= shd_dp_r;
                act_en_r  <= shd_en_r;
            end

            if (disp.load) begin
                shd_val_r <= disp.value_in;
                shd_dp_r  <= disp.dp_in;
                shd_en_r  <= disp.digit_en;
                pending_r <= 1'b1;
            end else if (boundary_s) begin
                pending_r <= 1'b0;
            end

            frame_done_r <= pre_boundary_s;
        end
    end

    // Registered cathode/anode drive, one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n_r <= 7'b1111111;
            dp_n_r  <= 1'b1;
            an_n_r  <= '1;
        end else begin
            seg_n_r <= seg_decode(act_val_r[idx_r]);
            dp_n_r  <= ~act_dp_r[idx_r];
            an_n_r  <= an_n_s;
        end
    end

    assign disp.seg_n      = seg_n_r;
    assign disp.dp_n       = dp_n_r;
    assign disp.an_n       = an_n_r;
    assign disp.frame_done = frame_done_r;
    assign disp.pending    = pending_r;

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Randomized bench for hex_display_scan_ctrl (4 digits, REFRESH_DIV=4, BLANK_CYCLES=1)
// against a cycle-count based reference model.
module tb_hex_display_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_display_scan_ctrl_if #(.NUM_DIGITS(ND)) disp ();

    hex_display_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .disp (disp)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int phase  = 0;

    logic [15:0] act_v, shd_v, prv_v;
    logic [3:0]  act_d, shd_d, prv_d;
    logic [3:0]  act_e, shd_e, prv_e;
    logic        m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, phase %0d)", tag, got, exp, cyc, phase);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        act_v = '0; act_d = '0; act_e = '0;
        shd_v = '0; shd_d = '0; shd_e = '0;
        prv_v = '0; prv_d = '0; prv_e = '0;
        m_pend = 1'b0;
    endtask

    // Outputs seen in cycle cyc reflect the scan position and active buffer of cycle cyc-1
    task automatic check_cycle();
        int          cc;
        int          idx;
        int          presc;
        logic [3:0]  nib;
        logic [3:0]  one4;
        logic        lit;
        logic [6:0]  es;
        logic        ed;
        logic [3:0]  ea;
        cc   = cyc - 1;
        one4 = 4'b0001;
        if (cc < 0) begin
            es = 7'b1111111; ed = 1'b1; ea = 4'hF;
        end else begin
            idx   = (cc / RD) % ND;
            presc = cc % RD;
            nib   = 4'((prv_v >> (4 * idx)) & 16'hF);
            es    = SEG_TAB[nib];
            ed    = ~prv_d[idx];
            lit   = prv_e[idx] && (presc >= BC);
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && (prv_v >> (4 * idx)) == 16'h0 && !prv_d[idx]) lit = 1'b0;
`endif
            ea = lit ? ~(one4 << idx) : 4'hF;
        end
        chk("seg_n", 32'(disp.seg_n), 32'(es));
        chk("dp_n", 32'(disp.dp_n), 32'(ed));
        chk("an_n", 32'(disp.an_n), 32'(ea));
        chk("frame_done", 32'(disp.frame_done), 32'((cyc % FRAME) == FRAME - 1));
        chk("pending", 32'(disp.pending), 32'(m_pend));
    endtask

    task automatic set_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
        disp.load     = 1'b1;
        disp.value_in = v;
        disp.digit_en = e;
        disp.dp_in    = d;
    endtask

    task automatic drive();
        disp.load = 1'b0;
        if (phase == 0 && cyc == 20)       set_load(16'h3A7F, 4'hF, 4'h0);
        else if (phase == 0 && cyc == 40)  set_load(16'h1111, 4'hF, 4'h0);
        else if (phase == 0 && cyc == 47)  set_load(16'h2222, 4'hF, 4'h0);
        else if (phase == 0 && cyc == 70)  set_load(16'h1234, 4'b0101, 4'b0001);
        else if (phase == 0 && cyc == 100) set_load(16'h1111, 4'hF, 4'h0);
        else if (phase == 0 && cyc == 104) set_load(16'h2222, 4'hF, 4'h0);
        else if (phase == 0 && cyc == 302) set_load(16'hBEEF, 4'hF, 4'hF);
        else if ((phase == 1 || cyc >= 120) &&
                 ($urandom_range(0, 7) == 0 ||
                  ((cyc % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0))) begin
            set_load(($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                     ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom),
                     4'($urandom));
        end
    endtask

    task automatic model_step();
        prv_v = act_v; prv_d = act_d; prv_e = act_e;
        if ((cyc % FRAME) == FRAME - 1 && m_pend) begin
            act_v = shd_v; act_d = shd_d; act_e = shd_e;
            m_pend = 1'b0;
        end
        if (disp.load) begin
            shd_v = disp.value_in; shd_d = disp.dp_in; shd_e = disp.digit_en;
            m_pend = 1'b1;
        end
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle();
            drive();
            model_step();
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        disp.load     = 1'b0;
        disp.value_in = '0;
        disp.dp_in    = '0;
        disp.digit_en = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_cycles(304);

        // Asynchronous reset mid-slot with an update pending
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_an_n", 32'(disp.an_n), 32'hF);
        chk("rst_seg_n", 32'(disp.seg_n), 32'h7F);
        chk("rst_dp_n", 32'(disp.dp_n), 32'h1);
        chk("rst_frame_done", 32'(disp.frame_done), 32'h0);
        chk("rst_pending", 32'(disp.pending), 32'h0);
        @(negedge clk);
        disp.load = 1'b0;
        rst_n = 1'b1;
        #1;
        phase = 1;
        model_reset();
        run_cycles(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
